seg7_reader: RTL and testbench
==============================

Name: seg7_reader

Overview:
- Decoder counterpart of the display path: samples a 7-segment pattern bus and recovers the hex digit it shows.
- Inputs are synchronized, filtered for stability and checked for legality before a digit is reported.
- Used in loopback self-test, with the display driver output wired to this block's input, and to read external 7-seg sources through ui_in.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted; legal range 2..15.
- CNT_W, 8, width of the change counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- seg_in  input  7  segment lines; bit0=a … bit6=g; active-high; asynchronous to clk
- digit  output  4  last accepted legal hex value
- digit_valid  output  1  one-cycle pulse when a legal pattern is accepted
- blank  output  1  level; last accepted pattern was 7'h00
- err  output  1  level; last accepted pattern was non-blank and not a legal hex glyph
- change_cnt  output  CNT_W  count of accepted digit changes; wraps

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - digit=0, digit_valid=0, blank=1, err=0, change_cnt=0.
  - Sync flops, cand and stab_cnt cleared to 0.
- Synchronizer: two flops, s1<=seg_in, s2<=s1.
- Stability filter:
  - Registers cand[6:0] and stab_cnt[3:0].
  - If s2!=cand: cand<=s2, stab_cnt<=0.
  - Else if stab_cnt<STABLE_CYCLES: stab_cnt<=stab_cnt+1. The counter saturates at STABLE_CYCLES.
- Accept event:
  - Fires on the edge where s2==cand and stab_cnt==STABLE_CYCLES-1.
  - Fires exactly once per stable period; no repeat while the pattern is held.
- Latency: seg_in first sampled at edge k and then held → outputs update at edge k+STABLE_CYCLES+2.
- Legal glyphs (hex 0..F): 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Legal pattern on accept:
  - digit<=value, digit_valid=1 for one cycle, blank<=0, err<=0.
  - change_cnt<=change_cnt+1 only if value!=digit before the update, or the previous accept was blank/err.
- Pattern 7'h00 on accept: blank<=1, err<=0, digit holds, no pulse, no count.
- Any other pattern on accept: err<=1, blank<=0, digit holds, no pulse, no count.
- Glitches shorter than STABLE_CYCLES synchronized cycles are ignored. A glitch that returns to the same pattern re-arms the filter, and the resulting re-accept pulses digit_valid again without counting.
- change_cnt wraps all-ones→0 with no flag.
- rst mid-filter discards the candidate. The first accept after reset of glyph 0 does not count; glyph 0 is counted if it follows a blank or err accept.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: seg_in is inverted before s1 (common-anode source), so an input of 7'h7F reads as blank.
- Undefined: active-high input as above.
- Output behaviour is otherwise identical.

Decomposition:
- Package seg7_pkg:
  - SEG_W=7.
  - SEG_BLANK=7'h00.
  - The 16 glyph constants SEG_0..SEG_F.
  - The function or localparam table shared with the display encoder.
- Sub-module seg7_glyph_decode: combinational, pattern → {legal, value[3:0]}, instantiated once.

Test Plan:
- Reset, then hold seg_in=7'h3F (STABLE_CYCLES=4) → digit_valid pulses 6 edges after first sample; digit=0; blank=0; change_cnt=0.
- Step 7'h3F→7'h06→7'h5B, each held 10 cycles → two pulses, digit 1 then 2, change_cnt=2.
- Hold 7'h4F, inject a 2-cycle glitch to 7'h7F → no accept of 7F; 7'h4F re-accepted with a pulse; change_cnt unchanged.
- Hold 7'h49 → err=1, digit holds prior value, no pulse. Then 7'h00 → blank=1, err=0. Then 7'h71 → digit=F, err=0, blank=0, count+1.
- Toggle two legal glyphs 256 times with CNT_W=8 → change_cnt wraps to 0. Assert rst mid-filter → all outputs return to reset values on the next edge.
- With SEG_ACTIVE_LOW_EN defined, drive 7'h40 → digit=0 accepted.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyph constants, decode result type and encoder function.
package seg7_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_A = 7'h77;
   localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
   localparam logic [SEG_W-1:0] SEG_C = 7'h39;
   localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
   localparam logic [SEG_W-1:0] SEG_E = 7'h79;
   localparam logic [SEG_W-1:0] SEG_F = 7'h71;

   typedef struct packed {
      logic       legal;
      logic [3:0] value;
   } glyph_dec_t;

   // Single source of truth for the glyph set; the display encoder uses the same function.
   function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] value);
      logic [SEG_W-1:0] pat;
      case (value)
         4'h0:    pat = SEG_0;
         4'h1:    pat = SEG_1;
         4'h2:    pat = SEG_2;
         4'h3:    pat = SEG_3;
         4'h4:    pat = SEG_4;
         4'h5:    pat = SEG_5;
         4'h6:    pat = SEG_6;
         4'h7:    pat = SEG_7;
         4'h8:    pat = SEG_8;
         4'h9:    pat = SEG_9;
         4'hA:    pat = SEG_A;
         4'hB:    pat = SEG_B;
         4'hC:    pat = SEG_C;
         4'hD:    pat = SEG_D;
         4'hE:    pat = SEG_E;
         default: pat = SEG_F;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational segment pattern to {legal, hex value} lookup.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] pattern,
   output glyph_dec_t       dec
);

   always_comb begin
      dec = '0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == seg7_encode(4'(i))) begin
            dec.legal = 1'b1;
            dec.value = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - synchronize, stability-filter and decode a 7-seg bus into a hex digit.
// SEG_ACTIVE_LOW_EN: invert seg_in before the synchronizer for common-anode sources.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEG_W-1:0] seg_in,
   output logic [3:0]       digit,
   output logic             digit_valid,
   output logic             blank,
   output logic             err,
   output logic [CNT_W-1:0] change_cnt
);

   localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

   logic [SEG_W-1:0] seg_raw;
   logic [SEG_W-1:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d;
   logic [3:0]       stab_q, stab_d;
   logic [3:0]       digit_q, digit_d;
   logic             valid_q, valid_d;
   logic             blank_q, blank_d;
   logic             err_q, err_d;
   logic             special_q, special_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   glyph_dec_t       dec;

`ifdef SEG_ACTIVE_LOW_EN
   assign seg_raw = ~seg_in;
`else
   assign seg_raw = seg_in;
`endif

   seg7_glyph_decode u_decode (
      .pattern (cand_q),
      .dec     (dec)
   );

   always_comb begin
      s1_d      = seg_raw;
      s2_d      = s1_q;
      cand_d    = cand_q;
      stab_d    = stab_q;
      digit_d   = digit_q;
      valid_d   = 1'b0;
      blank_d   = blank_q;
      err_d     = err_q;
      special_d = special_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;

      if (s2_q != cand_q) begin
         cand_d = s2_q;
         stab_d = 4'd0;
      end else begin
         if (stab_q < STAB_MAX) stab_d = stab_q + 4'd1;
         accept = (stab_q == STAB_MAX - 4'd1);
      end

      // special_q remembers a blank/err accept so the next legal glyph counts even if unchanged.
      if (accept) begin
         if (dec.legal) begin
            if ((dec.value != digit_q) || special_q) cnt_d = cnt_q + CNT_W'(1);
            digit_d   = dec.value;
            valid_d   = 1'b1;
            blank_d   = 1'b0;
            err_d     = 1'b0;
            special_d = 1'b0;
         end else if (cand_q == SEG_BLANK) begin
            blank_d   = 1'b1;
            err_d     = 1'b0;
            special_d = 1'b1;
         end else begin
            blank_d   = 1'b0;
            err_d     = 1'b1;
            special_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         cand_q    <= '0;
         stab_q    <= '0;
         digit_q   <= '0;
         valid_q   <= 1'b0;
         blank_q   <= 1'b1;
         err_q     <= 1'b0;
         special_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         cand_q    <= cand_d;
         stab_q    <= stab_d;
         digit_q   <= digit_d;
         valid_q   <= valid_d;
         blank_q   <= blank_d;
         err_q     <= err_d;
         special_q <= special_d;
         cnt_q     <= cnt_d;
      end
   end

   assign digit       = digit_q;
   assign digit_valid = valid_q;
   assign blank       = blank_q;
   assign err         = err_q;
   assign change_cnt  = cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - randomized and directed bench for seg7_reader against a run-length reference model.
module tb_seg7_reader;

   localparam int STABLE = 4;
   localparam int CW     = 8;

   localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic          clk = 1'b0;
   logic          rst;
   logic [6:0]    seg_in;
   logic [3:0]    digit;
   logic          digit_valid;
   logic          blank;
   logic          err;
   logic [CW-1:0] change_cnt;

   always #5 clk = ~clk;

   seg7_reader #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .digit       (digit),
      .digit_valid (digit_valid),
      .blank       (blank),
      .err         (err),
      .change_cnt  (change_cnt)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: outputs plus the run of identical effective input samples.
   logic [3:0]    m_digit;
   logic          m_valid, m_blank, m_err, m_special;
   logic [CW-1:0] m_cnt;
   logic [6:0]    run_val;
   int            run_len;
   logic          p1_vld, p2_vld;
   logic [6:0]    p1_val, p2_val;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] to_phys(input logic [6:0] eff);
`ifdef SEG_ACTIVE_LOW_EN
      return ~eff;
`else
      return eff;
`endif
   endfunction

   task automatic model_apply(input logic [6:0] p);
      bit legal = 0;
      logic [3:0] val = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (GLY[i] == p) begin
            legal = 1;
            val   = 4'(i);
         end
      end
      if (legal) begin
         if (val != m_digit || m_special) m_cnt = m_cnt + 1'b1;
         m_digit = val; m_valid = 1; m_blank = 0; m_err = 0; m_special = 0;
      end else if (p == 7'h00) begin
         m_blank = 1; m_err = 0; m_special = 1;
      end else begin
         m_blank = 0; m_err = 1; m_special = 1;
      end
   endtask

   // A run of STABLE+1 identical samples is accepted two edges after its last sample.
   // Reset leaves the pipeline looking like three zero samples already seen.
   task automatic model_edge(input logic r, input logic [6:0] eff);
      if (r) begin
         m_digit = 0; m_valid = 0; m_blank = 1; m_err = 0; m_special = 0; m_cnt = 0;
         run_val = 7'h00; run_len = 3;
         p1_vld = 0; p2_vld = 0; p1_val = 0; p2_val = 0;
      end else begin
         m_valid = 0;
         if (p2_vld) model_apply(p2_val);
         p2_vld = p1_vld; p2_val = p1_val;
         if (eff == run_val) begin
            if (run_len < 1000) run_len++;
         end else begin
            run_val = eff; run_len = 1;
         end
         p1_vld = (run_len == STABLE + 1);
         p1_val = run_val;
      end
   endtask

   task automatic cycle(input logic r, input logic [6:0] eff);
      @(negedge clk);
      check_eq("outs", {17'h0, digit, digit_valid, blank, err, change_cnt},
                       {17'h0, m_digit, m_valid, m_blank, m_err, m_cnt});
      rst    = r;
      seg_in = to_phys(eff);
      @(posedge clk);
      model_edge(r, eff);
   endtask

   task automatic hold(input logic [6:0] eff, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, eff);
   endtask

   initial begin
      rst    = 1'b1;
      seg_in = to_phys(7'h3F);
      @(posedge clk);
      model_edge(1'b1, 7'h3F);
      cycle(1'b1, 7'h3F);

      // First accept after reset: pulse exactly STABLE+2 edges after first sample, no count.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 7'h3F);
         #1;
         if (i == 5) check_eq("pulse_early", {31'h0, digit_valid}, 32'd0);
         if (i == 6) check_eq("pulse_on_time", {31'h0, digit_valid}, 32'd1);
      end
      #1 check_eq("first_cnt", {24'h0, change_cnt}, 32'd0);
      check_eq("first_blank", {31'h0, blank}, 32'd0);

      hold(7'h06, 10);
      hold(7'h5B, 10);
      #1 check_eq("step_digit", {28'h0, digit}, 32'd2);
      check_eq("step_cnt", {24'h0, change_cnt}, 32'd2);

      hold(7'h4F, 10);
      hold(7'h7F, 2);
      hold(7'h4F, 10);
      #1 check_eq("glitch_cnt", {24'h0, change_cnt}, 32'd3);

      hold(7'h49, 10);
      #1 check_eq("err_lvl", {28'h0, digit, err}, {27'h0, 4'd3, 1'b1});
      hold(7'h00, 10);
      #1 check_eq("blank_lvl", {30'h0, blank, err}, 32'd2);
      hold(7'h71, 10);
      #1 check_eq("f_after_blank", {20'h0, digit, change_cnt}, {20'h0, 4'hF, 8'd4});

      cycle(1'b1, 7'h06);
      for (int t = 0; t < 256; t++) hold((t % 2 == 0) ? 7'h06 : 7'h5B, 6);
      hold(7'h5B, 4);
      #1 check_eq("cnt_wrap", {24'h0, change_cnt}, 32'd0);

      hold(7'h77, 3);
      cycle(1'b1, 7'h77);
      #1 check_eq("rst_mid", {17'h0, digit, digit_valid, blank, err, change_cnt},
                  {17'h0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0});
      hold(7'h77, 10);

      for (int s = 0; s < 300; s++) begin
         int kind = $urandom_range(0, 9);
         int len  = $urandom_range(1, 9);
         logic [6:0] p;
         if (kind <= 5)      p = GLY[$urandom_range(0, 15)];
         else if (kind == 6) p = 7'h00;
         else                p = 7'($urandom);
         if (kind == 9) begin
            for (int j = 0; j < (len % 2) + 1; j++) cycle(1'b1, p);
         end else begin
            hold(p, len);
         end
      end
      hold(7'h3F, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
